// File: rtl/task_answer_packer_if.sv
// Bundles the task-result input, the packed answer stream and the statistics outputs of the packer.
interface task_answer_packer_if #(
   parameter int LANE_WIDTH   = 8,
   parameter int LANES        = 8,
   parameter int ANSWER_WIDTH = 32,
   parameter int LAT_WIDTH    = 32
);
   localparam int CW = $clog2(LANES + 1);

   logic                          i_clear;
   logic                          i_in_valid;
   logic                          i_valid;
   logic [LANES*LANE_WIDTH-1:0]   i_data;
   logic [CW-1:0]                 i_lane_count;
   logic                          i_last;
   logic [ANSWER_WIDTH-1:0]       o_answer_data;
   logic [ANSWER_WIDTH/8-1:0]     o_answer_keep;
   logic                          o_answer_valid;
   logic                          o_answer_last;
   logic                          i_answer_ready;
   logic [31:0]                   o_size_bytes;
   logic [LAT_WIDTH-1:0]          o_latency;
   logic                          o_overflow;
   logic                          o_busy;

   modport master (
      output i_clear, i_in_valid, i_valid, i_data, i_lane_count, i_last, i_answer_ready,
      input  o_answer_data, o_answer_keep, o_answer_valid, o_answer_last,
             o_size_bytes, o_latency, o_overflow, o_busy
   );

   modport slave (
      input  i_clear, i_in_valid, i_valid, i_data, i_lane_count, i_last, i_answer_ready,
      output o_answer_data, o_answer_keep, o_answer_valid, o_answer_last,
             o_size_bytes, o_latency, o_overflow, o_busy
   );
endinterface

// File: rtl/task_answer_packer.sv
// Buffers multi-lane task-result beats, serialises their lanes and packs them little-endian
// into answer words with byte-keep, while tracking answer size, input latency and drops.
module task_answer_packer #(
   parameter int LANE_WIDTH   = 8,
   parameter int LANES        = 8,
   parameter int ANSWER_WIDTH = 32,
   parameter int FIFO_DEPTH   = 64,
   parameter int LAT_WIDTH    = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   task_answer_packer_if.slave  bus
);

   localparam int WL  = ANSWER_WIDTH / LANE_WIDTH;
   localparam int BPL = LANE_WIDTH / 8;
   localparam int KW  = ANSWER_WIDTH / 8;
   localparam int CW  = $clog2(LANES + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int SW  = (WL > 1) ? $clog2(WL) : 1;
   localparam int DW  = LANES * LANE_WIDTH;
   localparam int EW  = DW + CW + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   logic [EW-1:0]           mem [FIFO_DEPTH];
   logic [AW:0]             wrPtr_q, rdPtr_q;
   logic                    fifoEmpty, fifoFull, push, pop;
   logic [EW-1:0]           rdEntry;
   logic [CW-1:0]           effCnt;

   logic [31:0]             size_q;
   logic [32:0]             sizeSum;
   logic [31:0]             sizeNext;
   logic                    overflow_q;
   logic [LAT_WIDTH-1:0]    lat_q, latInc;
   logic                    armed_q, frozen_q;

   state_t                  state_q, state_d;
   logic [DW-1:0]           laneData_q, laneData_d;
   logic [CW-1:0]           laneCnt_q, laneCnt_d;
   logic [CW-1:0]           laneIdx_q, laneIdx_d;
   logic                    beatLast_q, beatLast_d;
   logic [ANSWER_WIDTH-1:0] accData_q, accData_d;
   logic [KW-1:0]           accKeep_q, accKeep_d;
   logic [SW-1:0]           slot_q, slot_d;
   logic [ANSWER_WIDTH-1:0] outData_q, outData_d;
   logic [KW-1:0]           outKeep_q, outKeep_d;
   logic                    outLast_q, outLast_d;

   logic [LANE_WIDTH-1:0]   curLane;
   logic [ANSWER_WIDTH-1:0] accDataIns;
   logic [KW-1:0]           accKeepIns;
   logic                    finalLane, slotFull, lanesLeft;

   // Full is derived from registered pointers, so a push in the same cycle as a pop from a
   // full FIFO is still dropped.
   assign fifoEmpty = (wrPtr_q == rdPtr_q);
   assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign effCnt    = (bus.i_lane_count == '0 || bus.i_lane_count > CW'(LANES)) ?
                      CW'(LANES) : bus.i_lane_count;
   assign push      = bus.i_valid & ~fifoFull;
   assign rdEntry   = mem[rdPtr_q[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (push)
         mem[wrPtr_q[AW-1:0]] <= {bus.i_last, effCnt, bus.i_data};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      end
   end

   assign sizeSum  = {1'b0, size_q} + 33'(effCnt) * 33'(BPL);
   assign sizeNext = sizeSum[32] ? 32'hFFFF_FFFF : sizeSum[31:0];
   assign latInc   = (&lat_q) ? lat_q : lat_q + 1'b1;

   // Clear beats everything here; a beat written alongside it is still stored but not counted.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         size_q     <= '0;
         overflow_q <= 1'b0;
         lat_q      <= '0;
         armed_q    <= 1'b0;
         frozen_q   <= 1'b0;
      end else if (bus.i_clear) begin
         size_q     <= '0;
         overflow_q <= 1'b0;
         lat_q      <= '0;
         armed_q    <= 1'b0;
         frozen_q   <= 1'b0;
      end else begin
         if (push) size_q <= sizeNext;
         if (bus.i_valid && fifoFull) overflow_q <= 1'b1;
         if (armed_q) begin
            lat_q <= latInc;
            if (bus.i_valid) begin
               armed_q  <= 1'b0;
               frozen_q <= 1'b1;
            end
         end else if (!frozen_q && bus.i_in_valid) begin
            lat_q <= '0;
            if (bus.i_valid) frozen_q <= 1'b1;
            else             armed_q  <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         laneData_q <= '0;
         laneCnt_q  <= '0;
         laneIdx_q  <= '0;
         beatLast_q <= 1'b0;
         accData_q  <= '0;
         accKeep_q  <= '0;
         slot_q     <= '0;
         outData_q  <= '0;
         outKeep_q  <= '0;
         outLast_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         laneData_q <= laneData_d;
         laneCnt_q  <= laneCnt_d;
         laneIdx_q  <= laneIdx_d;
         beatLast_q <= beatLast_d;
         accData_q  <= accData_d;
         accKeep_q  <= accKeep_d;
         slot_q     <= slot_d;
         outData_q  <= outData_d;
         outKeep_q  <= outKeep_d;
         outLast_q  <= outLast_d;
      end
   end

   assign curLane    = LANE_WIDTH'(laneData_q >> (32'(laneIdx_q) * LANE_WIDTH));
   assign accDataIns = accData_q | (ANSWER_WIDTH'(curLane) << (32'(slot_q) * LANE_WIDTH));
   assign accKeepIns = accKeep_q | (KW'({BPL{1'b1}}) << (32'(slot_q) * BPL));
   assign finalLane  = ((laneIdx_q + 1'b1) == laneCnt_q);
   assign slotFull   = (slot_q == SW'(WL - 1));
   assign lanesLeft  = (laneIdx_q != laneCnt_q);

   // A non-last beat ending mid-word leaves its lanes in the accumulator so the next beat
   // continues filling the same word.
   always_comb begin
      state_d    = state_q;
      laneData_d = laneData_q;
      laneCnt_d  = laneCnt_q;
      laneIdx_d  = laneIdx_q;
      beatLast_d = beatLast_q;
      accData_d  = accData_q;
      accKeep_d  = accKeep_q;
      slot_d     = slot_q;
      outData_d  = outData_q;
      outKeep_d  = outKeep_q;
      outLast_d  = outLast_q;
      pop        = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifoEmpty) begin
               pop     = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            laneIdx_d = laneIdx_q + 1'b1;
            if (slotFull || (finalLane && beatLast_q)) begin
               outData_d = accDataIns;
               outKeep_d = accKeepIns;
               outLast_d = finalLane & beatLast_q;
               slot_d    = '0;
               state_d   = HOLD;
            end else begin
               accData_d = accDataIns;
               accKeep_d = accKeepIns;
               slot_d    = slot_q + 1'b1;
               if (finalLane) begin
                  if (!fifoEmpty) pop     = 1'b1;
                  else            state_d = IDLE;
               end
            end
         end
         HOLD: begin
            if (bus.i_answer_ready) begin
               accData_d = '0;
               accKeep_d = '0;
               if (lanesLeft) begin
                  state_d = SHIFT;
               end else if (!fifoEmpty) begin
                  pop     = 1'b1;
                  state_d = SHIFT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         laneData_d = rdEntry[DW-1:0];
         laneCnt_d  = rdEntry[DW+CW-1:DW];
         beatLast_d = rdEntry[EW-1];
         laneIdx_d  = '0;
      end
   end

   assign bus.o_answer_data  = outData_q;
   assign bus.o_answer_keep  = outKeep_q;
   assign bus.o_answer_last  = outLast_q;
   assign bus.o_answer_valid = (state_q == HOLD);
   assign bus.o_size_bytes   = size_q;
   assign bus.o_latency      = lat_q;
   assign bus.o_overflow     = overflow_q;
   assign bus.o_busy         = !fifoEmpty || (state_q != IDLE);

endmodule

// File: tb/tb_task_answer_packer.sv
// Randomised scoreboard bench for task_answer_packer with directed corner cases.
module tb_task_answer_packer;

   localparam int LW    = 8;
   localparam int LANES = 8;
   localparam int WL    = 4;
   localparam int CW    = 4;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } expWord_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   readyMode;
   int   modelSize;

   expWord_t    expQ[$];
   logic [7:0]  pend[$];

   logic        prevHold;
   logic [31:0] prevData;
   logic [3:0]  prevKeep;
   logic        prevLast;

   task_answer_packer_if bus ();

   task_answer_packer dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: lanes of stored beats form a byte stream, cut into WL-lane words; a last beat
   // flushes whatever is pending as the final, possibly partial, word.
   function automatic void modelStore(input logic [63:0] d, input int cnt, input bit last);
      int n;
      n = (cnt == 0 || cnt > LANES) ? LANES : cnt;
      for (int i = 0; i < n; i++) pend.push_back(d[i*8 +: 8]);
      while (pend.size() >= WL || (last && pend.size() > 0)) begin
         expWord_t w;
         w.data = '0;
         w.keep = '0;
         for (int k = 0; k < WL && pend.size() > 0; k++) begin
            w.data[k*8 +: 8] = pend.pop_front();
            w.keep[k] = 1'b1;
         end
         w.last = last && (pend.size() == 0);
         expQ.push_back(w);
      end
      modelSize += n * (LW / 8);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [63:0] d, input int cnt, input bit last, input bit stored);
      bus.i_valid      = 1'b1;
      bus.i_data       = d;
      bus.i_lane_count = CW'(cnt);
      bus.i_last       = last;
      if (stored) modelStore(d, cnt, last);
      tick();
      bus.i_valid = 1'b0;
   endtask

   task automatic pulseClear();
      bus.i_clear = 1'b1;
      tick();
      bus.i_clear = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_valid"},    64'(bus.o_answer_valid), 64'd0);
      checkOutput({tag, "_data"},     64'(bus.o_answer_data),  64'd0);
      checkOutput({tag, "_keep"},     64'(bus.o_answer_keep),  64'd0);
      checkOutput({tag, "_last"},     64'(bus.o_answer_last),  64'd0);
      checkOutput({tag, "_size"},     64'(bus.o_size_bytes),   64'd0);
      checkOutput({tag, "_latency"},  64'(bus.o_latency),      64'd0);
      checkOutput({tag, "_overflow"}, 64'(bus.o_overflow),     64'd0);
      checkOutput({tag, "_busy"},     64'(bus.o_busy),         64'd0);
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while ((expQ.size() != 0 || bus.o_busy) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("[TB] FAIL drainTimeout: %0d words still expected, busy=%0b", expQ.size(), bus.o_busy);
      end
   endtask

   task automatic waitValid(input int budget);
      int n;
      n = 0;
      while (!bus.o_answer_valid && n < budget) begin
         tick();
         n++;
      end
      checkOutput("validArrives", 64'(bus.o_answer_valid), 64'd1);
   endtask

   initial begin
      bus.i_answer_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            0:       bus.i_answer_ready = 1'b0;
            1:       bus.i_answer_ready = 1'b1;
            default: bus.i_answer_ready = ($urandom_range(0, 99) < 60);
         endcase
      end
   end

   // Monitor: pops the scoreboard on every handshake and checks words held under backpressure.
   initial begin
      prevHold = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevHold = 1'b0;
         end else begin
            if (prevHold) begin
               checks++;
               if (!(bus.o_answer_valid && bus.o_answer_data == prevData &&
                     bus.o_answer_keep == prevKeep && bus.o_answer_last == prevLast)) begin
                  errors++;
                  $display("[TB] FAIL holdStable: got v=%0b d=0x%0h k=0x%0h l=%0b expected v=1 d=0x%0h k=0x%0h l=%0b",
                           bus.o_answer_valid, bus.o_answer_data, bus.o_answer_keep, bus.o_answer_last,
                           prevData, prevKeep, prevLast);
               end
            end
            if (bus.o_answer_valid && bus.i_answer_ready) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpectedWord: got d=0x%0h k=0x%0h l=%0b expected none",
                           bus.o_answer_data, bus.o_answer_keep, bus.o_answer_last);
               end else begin
                  expWord_t e;
                  e = expQ.pop_front();
                  checkOutput("wordData", 64'(bus.o_answer_data), 64'(e.data));
                  checkOutput("wordKeep", 64'(bus.o_answer_keep), 64'(e.keep));
                  checkOutput("wordLast", 64'(bus.o_answer_last), 64'(e.last));
               end
            end
            prevHold = bus.o_answer_valid && !bus.i_answer_ready;
            prevData = bus.o_answer_data;
            prevKeep = bus.o_answer_keep;
            prevLast = bus.o_answer_last;
         end
      end
   end

   initial begin
      checks           = 0;
      errors           = 0;
      modelSize        = 0;
      readyMode        = 1;
      rst              = 1'b1;
      bus.i_clear      = 1'b0;
      bus.i_in_valid   = 1'b0;
      bus.i_valid      = 1'b0;
      bus.i_data       = '0;
      bus.i_lane_count = '0;
      bus.i_last       = 1'b0;
      repeat (3) tick();
      checkAllZero("reset");
      rst = 1'b0;
      tick();

      $display("[TB] full beat split into two words");
      applyStimulus(64'h0807060504030201, 8, 1'b1, 1'b1);
      waitDrain(100);
      checkOutput("size8", 64'(bus.o_size_bytes), 64'(modelSize));

      $display("[TB] partial last beat and cross-beat packing");
      applyStimulus(64'h0000000000CCBBAA, 3, 1'b1, 1'b1);
      waitDrain(100);
      applyStimulus(64'h000000000000BBAA, 2, 1'b0, 1'b1);
      applyStimulus(64'h000000000000DDCC, 2, 1'b1, 1'b1);
      waitDrain(100);

      $display("[TB] backpressure hold");
      readyMode = 0;
      tick();
      tick();
      applyStimulus({$urandom, $urandom}, 8, 1'b1, 1'b1);
      waitValid(50);
      repeat (20) tick();
      readyMode = 1;
      waitDrain(200);

      $display("[TB] randomised traffic");
      readyMode = 2;
      for (int r = 0; r < 6; r++) begin
         for (int b = 0; b < 10; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            applyStimulus({$urandom, $urandom}, $urandom_range(0, 15),
                          (b == 9) || ($urandom_range(0, 3) == 0), 1'b1);
         end
         waitDrain(2000);
      end
      checkOutput("sizeRandom", 64'(bus.o_size_bytes), 64'(modelSize));
      checkOutput("noOverflow", 64'(bus.o_overflow), 64'd0);

      $display("[TB] overflow with stalled output");
      pulseClear();
      modelSize = 0;
      readyMode = 0;
      tick();
      tick();
      // The first beat is popped the cycle after it lands, so 64 more fit: beats 0..64 survive.
      for (int i = 0; i < 70; i++)
         applyStimulus({$urandom, $urandom}, 8, 1'b1, i < 65);
      checkOutput("overflowSet", 64'(bus.o_overflow), 64'd1);
      checkOutput("sizeStored", 64'(bus.o_size_bytes), 64'(modelSize));
      readyMode = 1;
      waitDrain(3000);
      bus.i_clear = 1'b1;
      applyStimulus(64'h1122334455667788, 5, 1'b1, 1'b1);
      bus.i_clear = 1'b0;
      modelSize = 0;
      checkOutput("overflowCleared", 64'(bus.o_overflow), 64'd0);
      checkOutput("sizeCleared", 64'(bus.o_size_bytes), 64'd0);
      waitDrain(200);

      $display("[TB] latency meter");
      pulseClear();
      bus.i_in_valid = 1'b1;
      tick();
      bus.i_in_valid = 1'b0;
      repeat (14) tick();
      applyStimulus({$urandom, $urandom}, 4, 1'b1, 1'b1);
      checkOutput("latency15", 64'(bus.o_latency), 64'd15);
      bus.i_in_valid = 1'b1;
      tick();
      bus.i_in_valid = 1'b0;
      repeat (5) tick();
      checkOutput("latencyFrozen", 64'(bus.o_latency), 64'd15);
      waitDrain(200);
      pulseClear();
      checkOutput("latencyCleared", 64'(bus.o_latency), 64'd0);
      bus.i_in_valid = 1'b1;
      applyStimulus({$urandom, $urandom}, 2, 1'b1, 1'b1);
      bus.i_in_valid = 1'b0;
      repeat (4) tick();
      checkOutput("latencySameCycle", 64'(bus.o_latency), 64'd0);
      waitDrain(200);

      $display("[TB] asynchronous reset mid-word");
      pulseClear();
      modelSize = 0;
      readyMode = 0;
      tick();
      tick();
      applyStimulus({$urandom, $urandom}, 8, 1'b1, 1'b1);
      waitValid(50);
      #2;
      rst = 1'b1;
      #1;
      checkAllZero("midReset");
      expQ.delete();
      pend.delete();
      modelSize = 0;
      tick();
      rst = 1'b0;
      readyMode = 1;
      tick();
      applyStimulus(64'h0000000000000000 | 64'hA1B2C3, 3, 1'b1, 1'b1);
      waitDrain(200);
      checkOutput("sizeAfterReset", 64'(bus.o_size_bytes), 64'(modelSize));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
